// File: rtl/seq_pc_reg.sv
// seq_pc_reg: architectural PC and processor status register for the SEQ Y86-64 core.
// It sits directly downstream of pc_update. On each enabled clock it either commits the
// next PC or freezes the core on a halt or an exception. Terminal states persist until
// reset.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   step_en       1 = commit this cycle's instruction, 0 = hold all state
//   new_pc        next PC from pc_update
//   icode         icode of the instruction in fetch (4'h0 = halt)
//   instr_valid   0 = fetch decoded an illegal icode/ifun
//   imem_error    instruction memory fetch fault
//   dmem_error    data memory access fault
//   PC            current architectural PC (registered)
//   stat          1 AOK, 2 HLT, 3 ADR, 4 INS (registered)
//   halted        stat != AOK (registered)
//   cycle_count   enabled cycles spent in RUN, saturating
//   retired_count committed instructions including halt, saturating
module seq_pc_reg #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] ADDR_LIMIT = 64'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_en,
  input  logic [63:0] new_pc,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_error,
  output logic [63:0] PC,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [31:0] cycle_count,
  output logic [31:0] retired_count
);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;
  localparam logic [3:0] IcodeHalt = 4'h0;

  typedef enum logic [1:0] {StRun, StHalt, StErr} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic        halted_q, halted_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ret_q, ret_d;

  logic [31:0] cyc_inc, ret_inc;

  // Saturating increments: hold at all-ones rather than wrapping.
  assign cyc_inc = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
  assign ret_inc = (ret_q == 32'hFFFF_FFFF) ? ret_q : ret_q + 32'd1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    stat_d   = stat_q;
    cyc_d    = cyc_q;
    ret_d    = ret_q;

    unique case (state_q)
      StRun: begin
        if (step_en) begin
          cyc_d = cyc_inc;
          // Faults that abort the instruction are checked before anything that completes it.
          if (imem_error) begin
            stat_d  = StatAdr;
            state_d = StErr;
          end else if (!instr_valid) begin
            stat_d  = StatIns;
            state_d = StErr;
          end else if (dmem_error) begin
            stat_d  = StatAdr;
            state_d = StErr;
          end else if (icode == IcodeHalt) begin
            stat_d  = StatHlt;
            state_d = StHalt;
            pc_d    = new_pc;
            ret_d   = ret_inc;
          end else if (new_pc >= ADDR_LIMIT) begin
            // The instruction itself completed; only the next fetch address is bad.
            stat_d  = StatAdr;
            state_d = StErr;
            ret_d   = ret_inc;
          end else begin
            pc_d  = new_pc;
            ret_d = ret_inc;
          end
        end
      end
      StHalt, StErr: begin
        // Absorbing: only reset leaves these states.
      end
      default: begin
        state_d = StErr;
      end
    endcase

    halted_d = (stat_d != StatAok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      stat_q   <= StatAok;
      halted_q <= 1'b0;
      cyc_q    <= 32'd0;
      ret_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      stat_q   <= stat_d;
      halted_q <= halted_d;
      cyc_q    <= cyc_d;
      ret_q    <= ret_d;
    end
  end

  assign PC            = pc_q;
  assign stat          = stat_q;
  assign halted        = halted_q;
  assign cycle_count   = cyc_q;
  assign retired_count = ret_q;

endmodule
